// File: rtl/pc_control_unit.sv
// Fetch/decode control: holds the PC, fetches over a busy handshake and decodes IR into regfile/ALU controls.
// Every instruction takes FETCH (>=1 cycle, stalls while INSTR_BUSY) then exactly one EXEC cycle.
module pc_control_unit #(
    parameter int                    PC_WIDTH       = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC       = '0,
    parameter int                    REG_ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH     = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [31:0]               INSTRUCTION,
    input  logic                      INSTR_BUSY,
    input  logic                      ZERO,
    output logic [PC_WIDTH-1:0]       PC,
    output logic                      INSTR_READ,
    output logic [REG_ADDR_WIDTH-1:0] WRITEREG,
    output logic [REG_ADDR_WIDTH-1:0] READREG1,
    output logic [REG_ADDR_WIDTH-1:0] READREG2,
    output logic                      WRITE,
    output logic [2:0]                ALUOP,
    output logic [DATA_WIDTH-1:0]     IMMEDIATE,
    output logic                      IMM_SEL,
    output logic                      NEG_SEL,
    output logic                      ILLEGAL
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t        state;
    logic [31:0]   ir;
    logic [7:0]    opcode;
    logic [7:0]    offset;
    logic          taken;
    logic [PC_WIDTH-1:0] pc_next_seq;
    logic [PC_WIDTH-1:0] pc_target;

    assign opcode    = ir[31:24];
    assign offset    = ir[23:16];
    assign WRITEREG  = ir[16 +: REG_ADDR_WIDTH];
    assign READREG1  = ir[8 +: REG_ADDR_WIDTH];
    assign READREG2  = ir[0 +: REG_ADDR_WIDTH];
    assign IMMEDIATE = ir[0 +: DATA_WIDTH];

    assign INSTR_READ  = (state == FETCH) && !RESET;
    assign pc_next_seq = PC + PC_WIDTH'(4);
    // Word offset: sign-extend the byte field and scale by 4.
    assign pc_target   = pc_next_seq + {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};

    always_comb begin
        WRITE   = 1'b0;
        ALUOP   = 3'b000;
        IMM_SEL = 1'b0;
        NEG_SEL = 1'b0;
        ILLEGAL = 1'b0;
        taken   = 1'b0;
        if (state == EXEC && !RESET) begin
            case (opcode)
                8'h00: begin IMM_SEL = 1'b1; WRITE = 1'b1; end
                8'h01: WRITE = 1'b1;
                8'h02: begin ALUOP = 3'b001; WRITE = 1'b1; end
                8'h03: begin ALUOP = 3'b001; NEG_SEL = 1'b1; WRITE = 1'b1; end
                8'h04: begin ALUOP = 3'b010; WRITE = 1'b1; end
                8'h05: begin ALUOP = 3'b011; WRITE = 1'b1; end
                8'h06: taken = 1'b1;
                8'h07: begin ALUOP = 3'b001; NEG_SEL = 1'b1; taken = ZERO; end
                default: ILLEGAL = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC    <= RESET_PC;
            state <= FETCH;
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!INSTR_BUSY) begin
                        ir    <= INSTRUCTION;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    PC    <= taken ? pc_target : pc_next_seq;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench: expected decode pushed to a scoreboard at fetch, popped and compared in EXEC.
module tb_pc_control_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_BUSY;
    logic        ZERO;
    logic [31:0] PC;
    logic        INSTR_READ;
    logic [2:0]  WRITEREG, READREG1, READREG2;
    logic        WRITE;
    logic [2:0]  ALUOP;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL, NEG_SEL, ILLEGAL;

    pc_control_unit dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_BUSY(INSTR_BUSY),
        .ZERO(ZERO), .PC(PC), .INSTR_READ(INSTR_READ), .WRITEREG(WRITEREG),
        .READREG1(READREG1), .READREG2(READREG2), .WRITE(WRITE), .ALUOP(ALUOP),
        .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       write;
        logic [2:0] wr, rr1, rr2, aluop;
        logic [7:0] imm;
        logic       imm_sel, neg_sel, illegal;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic exp_t decode_model(input logic [31:0] i);
        exp_t e;
        e.write = 0; e.aluop = 0; e.imm_sel = 0; e.neg_sel = 0; e.illegal = 0;
        e.wr = i[18:16]; e.rr1 = i[10:8]; e.rr2 = i[2:0]; e.imm = i[7:0];
        case (i[31:24])
            8'h00: begin e.imm_sel = 1; e.write = 1; end
            8'h01: e.write = 1;
            8'h02: begin e.aluop = 3'd1; e.write = 1; end
            8'h03: begin e.aluop = 3'd1; e.neg_sel = 1; e.write = 1; end
            8'h04: begin e.aluop = 3'd2; e.write = 1; end
            8'h05: begin e.aluop = 3'd3; e.write = 1; end
            8'h06: ;
            8'h07: begin e.aluop = 3'd1; e.neg_sel = 1; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called #1 after an edge with the DUT in FETCH; leaves it #1 after the EXEC->FETCH edge.
    task automatic fetch_exec(input string tag, input logic [31:0] instr, input logic z,
                              input logic [31:0] exp_pc);
        exp_t e;
        int   n;
        q.push_back(decode_model(instr));
        check({tag, ".read"}, INSTR_READ, 1);
        INSTRUCTION = instr;
        INSTR_BUSY  = 1'b0;
        ZERO        = ~z;
        n = 0;
        do begin
            tick();
            n++;
        end while (INSTR_READ !== 1'b0 && n < 4);
        check({tag, ".exec_reached"}, INSTR_READ, 0);
        INSTR_BUSY  = 1'b1;
        INSTRUCTION = $urandom;
        ZERO        = z;
        #1;
        e = q.pop_front();
        check({tag, ".write"},   WRITE,     e.write);
        check({tag, ".wr"},      WRITEREG,  e.wr);
        check({tag, ".rr1"},     READREG1,  e.rr1);
        check({tag, ".rr2"},     READREG2,  e.rr2);
        check({tag, ".aluop"},   ALUOP,     e.aluop);
        check({tag, ".imm"},     IMMEDIATE, e.imm);
        check({tag, ".imm_sel"}, IMM_SEL,   e.imm_sel);
        check({tag, ".neg_sel"}, NEG_SEL,   e.neg_sel);
        check({tag, ".illegal"}, ILLEGAL,   e.illegal);
        tick();
        check({tag, ".pc"},           PC,      exp_pc);
        check({tag, ".fetch_write"},  WRITE,   0);
        check({tag, ".fetch_illegal"}, ILLEGAL, 0);
        check({tag, ".fetch_aluop"},  ALUOP,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; INSTRUCTION = '0; INSTR_BUSY = 1'b1; ZERO = 1'b0;
        tick();
        tick();
        check("reset.pc",      PC,         0);
        check("reset.read",    INSTR_READ, 0);
        check("reset.write",   WRITE,      0);
        check("reset.illegal", ILLEGAL,    0);
        RESET = 1'b0;
        #1;
        check("post_reset.read", INSTR_READ, 1);

        fetch_exec("loadi", 32'h0004002A, 1'b0, 32'h4);

        INSTR_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ZERO = i[0];
            tick();
            check("busy.read",  INSTR_READ, 1);
            check("busy.write", WRITE,      0);
            check("busy.pc",    PC,         32'h4);
        end

        fetch_exec("sub",      32'h03020501, 1'b0, 32'h8);
        fetch_exec("j_fwd1",   32'h06010000, 1'b0, 32'h10);
        fetch_exec("beq_tk",   32'h07FE0000, 1'b1, 32'h0C);
        fetch_exec("j_zero",   32'h06000000, 1'b0, 32'h10);
        fetch_exec("beq_nt",   32'h07FE0000, 1'b0, 32'h14);

        INSTRUCTION = 32'h02030102;
        INSTR_BUSY  = 1'b0;
        tick();
        INSTR_BUSY = 1'b1;
        check("add_rst.write_before", WRITE, 1);
        RESET = 1'b1;
        #1;
        check("add_rst.write",  WRITE,      0);
        check("add_rst.read",   INSTR_READ, 0);
        tick();
        check("add_rst.pc",     PC,         0);
        RESET = 1'b0;
        #1;
        check("add_rst.fetch",  INSTR_READ, 1);

        fetch_exec("j_fwd2",   32'h06020000, 1'b0, 32'h0C);
        fetch_exec("j_back",   32'h06FB0000, 1'b0, 32'hFFFFFFFC);
        fetch_exec("illegal",  32'h09000000, 1'b0, 32'h0);
        fetch_exec("mov",      32'h01070300, 1'b1, 32'h4);
        fetch_exec("and",      32'h04010203, 1'b0, 32'h8);
        fetch_exec("or",       32'h05060704, 1'b1, 32'hC);

        check("scoreboard.empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
